// File: rtl/rf_pkg.sv
// Shared defaults, types and helpers for the multi-ported register file.
package rf_pkg;

  localparam int RF_ADDR  = 5;
  localparam int RF_BUS_W = 32;

  // Widest busy vector popcount accepts (ADDR up to 10).
  localparam int POP_MAX = 1024;

  typedef logic [RF_ADDR-1:0]  reg_addr_t;
  typedef logic [RF_BUS_W-1:0] reg_data_t;
  typedef logic [POP_MAX-1:0]  pop_vec_t;

  function automatic int unsigned popcount(input pop_vec_t v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX; i++) n += {31'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: zero-register check, write bypass priority mux, busy select.
module rf_read_port #(
  parameter int ADDR   = 5,
  parameter int BUS_W  = 32,
  parameter int NW     = 1,
  parameter int BYPASS = 1
) (
  input  logic [ADDR-1:0]     addr,
  input  logic [BUS_W-1:0]    stored_data,
  input  logic                stored_busy,
  input  logic [NW-1:0]       w_en,
  input  logic [NW*ADDR-1:0]  w_addr,
  input  logic [NW*BUS_W-1:0] w_data,
  input  logic                bypass_en,
  output logic [BUS_W-1:0]    data,
  output logic                busy
);

  // NOTE: every output gets a default before any conditional assignment, so no latch is inferred.
  always_comb begin
    data = stored_data;
    busy = stored_busy;
    if (BYPASS != 0 && bypass_en) begin
      // Ascending scan: the highest matching write port is the last to assign.
      for (int k = 0; k < NW; k++) begin
        if (w_en[k] && w_addr[k*ADDR +: ADDR] == addr) begin
          data = w_data[k*BUS_W +: BUS_W];
          busy = 1'b0;
        end
      end
    end
    if (addr == '0) begin
      data = '0;
      busy = 1'b0;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-ported register file with hardwired zero register, per-register busy scoreboard
// and optional same-cycle write-to-read bypass.
module register_file_mp
  import rf_pkg::*;
#(
  parameter int ADDR   = RF_ADDR,
  parameter int BUS_W  = RF_BUS_W,
  parameter int NR     = 2,
  parameter int NW     = 1,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NW-1:0]       w_en,
  input  logic [NW*ADDR-1:0]  w_addr,
  input  logic [NW*BUS_W-1:0] w_data,
  input  logic [NR*ADDR-1:0]  r_addr,
  output logic [NR*BUS_W-1:0] r_data,
  output logic [NR-1:0]       r_busy,
  input  logic                iss_valid,
  input  logic [ADDR-1:0]     iss_addr,
  output logic [ADDR:0]       busy_cnt
);

  localparam int DEPTH = 2**ADDR;

  typedef logic [ADDR:0] cnt_t;

  logic [BUS_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;

  // Writes clear, then an issue sets, so a same-cycle issue to the written register keeps it busy.
  always_comb begin
    busy_next = busy;
    for (int k = 0; k < NW; k++) begin
      if (w_en[k]) busy_next[w_addr[k*ADDR +: ADDR]] = 1'b0;
    end
    if (iss_valid) busy_next[iss_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // NOTE: storage is a flop array rather than an SRAM macro, so clearing it on reset is legal.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      // NOTE: non-blocking writes in an ascending loop let the highest enabled port win a collision.
      for (int k = 0; k < NW; k++) begin
        if (w_en[k] && w_addr[k*ADDR +: ADDR] != '0)
          mem[w_addr[k*ADDR +: ADDR]] <= w_data[k*BUS_W +: BUS_W];
      end
      busy     <= busy_next;
      busy_cnt <= cnt_t'(popcount(pop_vec_t'(busy_next)));
    end
  end

  for (genvar j = 0; j < NR; j++) begin : g_read
    rf_read_port #(
      .ADDR   (ADDR),
      .BUS_W  (BUS_W),
      .NW     (NW),
      .BYPASS (BYPASS)
    ) u_read_port (
      .addr        (r_addr[j*ADDR +: ADDR]),
      .stored_data (mem[r_addr[j*ADDR +: ADDR]]),
      .stored_busy (busy[r_addr[j*ADDR +: ADDR]]),
      .w_en        (w_en),
      .w_addr      (w_addr),
      .w_data      (w_data),
      .bypass_en   (~rst),
      .data        (r_data[j*BUS_W +: BUS_W]),
      .busy        (r_busy[j])
    );
  end

endmodule
